// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage in-order core.
// Ports: clk, rst (sync, active-low); ID/EX/MEM/WB hazard inputs;
//   pc_en..mem_wb_en register enables, if_id_flush, id_ex_bubble,
//   pc_sel_target; halted/err sticky status; stall_cycles counter.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [2:0]  ex_rd,
  input  logic        ex_mem_to_reg,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pc_sel_target,
  output logic        halted,
  output logic        err,
  output logic [15:0] stall_cycles
);

  // One spare bit so the count can step past MEM_TIMEOUT
  localparam int WCW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_nxt;
  logic [15:0]      r_stall;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;
  logic w_hold;
  logic w_timeout;
  logic w_active;
  logic w_stall_inc;

  assign w_rs_hit   = id_uses_rs && (id_rs == ex_rd);
  assign w_rt_hit   = id_uses_rt && (id_rt == ex_rd);
  assign w_load_use = ex_mem_to_reg && (w_rs_hit || w_rt_hit);

  // Halt and memory wait both freeze every stage
  assign w_hold    = wb_halt || mem_busy;
  assign w_timeout = (r_wait_cnt >= WCW'(MEM_TIMEOUT));
  assign w_active  = (r_state == RUN) || (r_state == MEM_WAIT);

  assign w_stall_inc = w_active && !pc_en &&
                       (r_stall != 16'hFFFF);

  assign stall_cycles = r_stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_stall_inc) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      RUN, MEM_WAIT: begin
        if (wb_halt) begin
          w_state_nxt = HALTED;
        end else if (mem_busy) begin
          w_wait_nxt  = r_wait_cnt + 1'b1;
          // Count already holds MEM_TIMEOUT busy cycles
          if (w_timeout) begin
            w_state_nxt = ERROR;
          end else begin
            w_state_nxt = MEM_WAIT;
          end
        end else begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      ERROR:   w_state_nxt = ERROR;
      default: w_state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pc_sel_target = 1'b0;
    halted        = 1'b0;
    err           = 1'b0;
    if (!rst) begin
      // Clock NOPs into every stage while reset is held
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (r_state)
        RUN, MEM_WAIT: begin
          if (!w_hold) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (ex_branch_taken) begin
              // Redirect wins over load-use: the
              // dependent ID instruction is squashed
              pc_en         = 1'b1;
              if_id_en      = 1'b1;
              if_id_flush   = 1'b1;
              id_ex_bubble  = 1'b1;
              pc_sel_target = 1'b1;
            end else if (w_load_use) begin
              id_ex_bubble = 1'b1;
            end else begin
              pc_en    = 1'b1;
              if_id_en = 1'b1;
            end
          end
        end
        HALTED:  halted = 1'b1;
        ERROR:   err    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios
// plus randomized traffic against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int TO = 255;

  // {pc,ifid,idex,exmem,memwb,flush,bubble,sel,halted,err}
  localparam logic [9:0] O_RST  = 10'b1111111000;
  localparam logic [9:0] O_NORM = 10'b1111100000;
  localparam logic [9:0] O_BR   = 10'b1111111100;
  localparam logic [9:0] O_LU   = 10'b0011101000;
  localparam logic [9:0] O_HOLD = 10'b0000000000;
  localparam logic [9:0] O_HALT = 10'b0000000010;
  localparam logic [9:0] O_ERR  = 10'b0000000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_mem_to_reg, ex_branch_taken;
  logic        mem_busy, wb_halt;
  logic        pc_en, if_id_en, id_ex_en;
  logic        ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_bubble;
  logic        pc_sel_target, halted, err;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_halt;
  bit m_err;
  int m_busy;
  int m_stall;

  wire [9:0] w_out = {pc_en, if_id_en, id_ex_en,
                      ex_mem_en, mem_wb_en, if_id_flush,
                      id_ex_bubble, pc_sel_target,
                      halted, err};

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_rd           (ex_rd),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .wb_halt         (wb_halt),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pc_sel_target   (pc_sel_target),
    .halted          (halted),
    .err             (err),
    .stall_cycles    (stall_cycles)
  );

  function automatic logic [9:0] model_out();
    bit lu;
    lu = ex_mem_to_reg &&
         ((id_uses_rs && id_rs == ex_rd) ||
          (id_uses_rt && id_rt == ex_rd));
    if (!rst)            return O_RST;
    if (m_halt)          return O_HALT;
    if (m_err)           return O_ERR;
    if (wb_halt)         return O_HOLD;
    if (mem_busy)        return O_HOLD;
    if (ex_branch_taken) return O_BR;
    if (lu)              return O_LU;
    return O_NORM;
  endfunction

  task automatic drive(input int r, input int hl,
                       input int bz, input int br,
                       input int ld, input int rs,
                       input int rt, input int rd,
                       input int urs, input int urt);
    @(negedge clk);
    rst             = 1'(r);
    wb_halt         = 1'(hl);
    mem_busy        = 1'(bz);
    ex_branch_taken = 1'(br);
    ex_mem_to_reg   = 1'(ld);
    id_rs           = 3'(rs);
    id_rt           = 3'(rt);
    ex_rd           = 3'(rd);
    id_uses_rs      = 1'(urs);
    id_uses_rt      = 1'(urt);
    #1;
  endtask

  // Advance one clock and step the model
  task automatic tick();
    logic [9:0] e;
    e = model_out();
    @(posedge clk);
    if (!rst) begin
      m_halt  = 0;
      m_err   = 0;
      m_busy  = 0;
      m_stall = 0;
    end else if (!m_halt && !m_err) begin
      if (!e[9] && m_stall < 65535) m_stall++;
      if (wb_halt) begin
        m_halt = 1;
      end else if (mem_busy) begin
        m_busy++;
        if (m_busy > TO) m_err = 1;
      end else begin
        m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 1, 1, 2, 2, 2, 1, 1);
    n_tests++;
    if (w_out !== O_RST) begin
      n_fail++;
      $display("FAIL reset_out act=%b exp=%b", w_out, O_RST);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stall act=%0d exp=0", stall_cycles);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_NORM) begin
      n_fail++;
      $display("FAIL reset_run act=%b exp=%b", w_out, O_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 1, 3, 0, 3, 1, 0);
    n_tests++;
    if (w_out !== O_LU) begin
      n_fail++;
      $display("FAIL lu_rs act=%b exp=%b", w_out, O_LU);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_stall act=%0d exp=1", stall_cycles);
    end
    drive(1, 0, 0, 0, 1, 0, 5, 5, 0, 1);
    n_tests++;
    if (w_out !== O_LU) begin
      n_fail++;
      $display("FAIL lu_rt act=%b exp=%b", w_out, O_LU);
    end
    tick();
    drive(1, 0, 0, 0, 1, 3, 3, 3, 0, 0);
    n_tests++;
    if (w_out !== O_NORM) begin
      n_fail++;
      $display("FAIL lu_nouse act=%b exp=%b", w_out, O_NORM);
    end
    tick();
    drive(1, 0, 0, 0, 0, 3, 0, 3, 1, 0);
    n_tests++;
    if (w_out !== O_NORM) begin
      n_fail++;
      $display("FAIL lu_noload act=%b exp=%b", w_out, O_NORM);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd2) begin
      n_fail++;
      $display("FAIL lu_stall2 act=%0d exp=2", stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 0, 0, 1, 1, 3, 0, 3, 1, 0);
    n_tests++;
    if (w_out !== O_BR) begin
      n_fail++;
      $display("FAIL br_lu act=%b exp=%b", w_out, O_BR);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL br_stall act=%0d exp=0", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (w_out !== O_HOLD) begin
        n_fail++;
        $display("FAIL mw_hold%0d act=%b exp=%b",
                 i, w_out, O_HOLD);
      end
      tick();
    end
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_BR) begin
      n_fail++;
      $display("FAIL mw_branch act=%b exp=%b", w_out, O_BR);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd4) begin
      n_fail++;
      $display("FAIL mw_stall act=%0d exp=4", stall_cycles);
    end
    drive(1, 0, 1, 0, 1, 4, 0, 4, 1, 0);
    tick();
    drive(1, 0, 0, 0, 1, 4, 0, 4, 1, 0);
    n_tests++;
    if (w_out !== O_LU) begin
      n_fail++;
      $display("FAIL mw_exit_lu act=%b exp=%b", w_out, O_LU);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_RST) begin
      n_fail++;
      $display("FAIL mw_rst act=%b exp=%b", w_out, O_RST);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_NORM || stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL mw_after_rst act=%b/%0d exp=%b/0",
               w_out, stall_cycles, O_NORM);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_NORM) begin
      n_fail++;
      $display("FAIL to_edge act=%b exp=%b", w_out, O_NORM);
    end
    tick();
    do_reset();
    for (int i = 0; i < TO + 1; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_ERR) begin
      n_fail++;
      $display("FAIL to_err act=%b exp=%b", w_out, O_ERR);
    end
    tick();
    drive(1, 0, 0, 1, 1, 1, 1, 1, 1, 1);
    n_tests++;
    if (w_out !== O_ERR) begin
      n_fail++;
      $display("FAIL to_sticky act=%b exp=%b", w_out, O_ERR);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd256) begin
      n_fail++;
      $display("FAIL to_stall act=%0d exp=256", stall_cycles);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_NORM) begin
      n_fail++;
      $display("FAIL to_rst act=%b exp=%b", w_out, O_NORM);
    end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_HOLD) begin
      n_fail++;
      $display("FAIL halt_hold act=%b exp=%b", w_out, O_HOLD);
    end
    tick();
    drive(1, 0, 1, 1, 1, 3, 3, 3, 1, 1);
    n_tests++;
    if (w_out !== O_HALT) begin
      n_fail++;
      $display("FAIL halt_state act=%b exp=%b", w_out, O_HALT);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL halt_stall act=%0d exp=1", stall_cycles);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_RST) begin
      n_fail++;
      $display("FAIL halt_rst act=%b exp=%b", w_out, O_RST);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (w_out !== O_NORM || stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL halt_exit act=%b/%0d exp=%b/0",
               w_out, stall_cycles, O_NORM);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) >= 2) ? 1 : 0,
            ($urandom_range(0, 199) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 4) == 0) ? 1 : 0,
            ($urandom_range(0, 1) == 0) ? 1 : 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1));
      e = model_out();
      n_tests++;
      if (w_out !== e) begin
        n_fail++;
        $display("FAIL rnd_out%0d act=%b exp=%b", i, w_out, e);
      end
      tick();
      n_tests++;
      if (stall_cycles !== 16'(m_stall)) begin
        n_fail++;
        $display("FAIL rnd_stall%0d act=%0d exp=%0d",
                 i, stall_cycles, m_stall);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(1, 0, 0, 0, 1, 2, 0, 2, 1, 0);
      tick();
    end
    n_tests++;
    if (stall_cycles !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre act=%h exp=fffe", stall_cycles);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 2, 0, 2, 1, 0);
      n_tests++;
      if (w_out !== O_LU) begin
        n_fail++;
        $display("FAIL sat_out%0d act=%b exp=%b", i, w_out, O_LU);
      end
      tick();
      n_tests++;
      if (stall_cycles !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL sat_hold%0d act=%h exp=ffff",
                 i, stall_cycles);
      end
    end
  endtask

  initial begin
    m_halt  = 0;
    m_err   = 0;
    m_busy  = 0;
    m_stall = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, as the consecutive mem_busy cycles that trigger the ERROR state.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port id_rs  input  3  ID-stage source register 1.
REQ-005 The block SHALL have port id_rt  input  3  ID-stage source register 2.
REQ-006 The block SHALL have ports id_uses_rs and id_uses_rt  input  1 each  ID instruction reads that source.
REQ-007 The block SHALL have port ex_rd  input  3  EX-stage destination register.
REQ-008 The block SHALL have port ex_mem_to_reg  input  1  EX instruction is a load.
REQ-009 The block SHALL have port ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-010 The block SHALL have port mem_busy  input  1  data memory not ready, MEM stage must hold.
REQ-011 The block SHALL have port wb_halt  input  1  HALT instruction in WB.
REQ-012 The block SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register enables.
REQ-013 The block SHALL have port if_id_flush  output  1  load NOP into IF/ID.
REQ-014 The block SHALL have port id_ex_bubble  output  1  drive the ID/EX reset/NOP-insert input.
REQ-015 The block SHALL have port pc_sel_target  output  1  PC loads branch target.
REQ-016 The block SHALL have ports halted and err  output  1 each  sticky status.
REQ-017 The block SHALL have port stall_cycles  output  16  saturating stall counter.

Function
REQ-018 The block SHALL implement states RUN, MEM_WAIT, HALTED, ERROR, registered; outputs SHALL be combinational from state and inputs.
REQ-019 Load-use SHALL be ex_mem_to_reg & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-020 The block SHALL apply priority in RUN and MEM_WAIT: wb_halt > mem_busy > ex_branch_taken > load-use > normal.
REQ-021 Normal cycles SHALL have all five enables 1, and flush, bubble, pc_sel_target 0.
REQ-022 On wb_halt=1, all enables SHALL be 0, next state HALTED.
REQ-023 On mem_busy=1, all enables SHALL be 0, next state MEM_WAIT, wait_cnt+1.
REQ-024 On ex_branch_taken=1, all enables SHALL be 1, if_id_flush=1, id_ex_bubble=1, pc_sel_target=1, for exactly that cycle.
REQ-025 On load-use, pc_en=0, if_id_en=0, id_ex_bubble=1, and id_ex_en, ex_mem_en, mem_wb_en=1, for one cycle.
REQ-026 In MEM_WAIT with mem_busy=0, the block SHALL apply the lower-priority rules in that same cycle, return to RUN and clear wait_cnt.
REQ-027 A branch held during a stall SHALL be serviced on the first non-busy cycle because EX/MEM is frozen.
REQ-028 When wait_cnt reaches MEM_TIMEOUT with mem_busy still 1, the block SHALL enter ERROR.
REQ-029 HALTED and ERROR SHALL force all enables 0, all flush/bubble/pc_sel_target 0, and be exited only by reset.
REQ-030 halted SHALL be 1 exactly in HALTED; err SHALL be 1 exactly in ERROR.
REQ-031 stall_cycles SHALL increment when pc_en=0 in RUN or MEM_WAIT, and SHALL saturate at 16'hFFFF.

Reset
REQ-032 While rst=0 at a clock edge, the next state SHALL be RUN, with wait_cnt=0 and stall_cycles=0.
REQ-033 While rst=0, all enables SHALL be 1, if_id_flush=1, id_ex_bubble=1, pc_sel_target=0, halted=0, err=0, so the pipeline fills with NOPs.
REQ-034 Reset asserted in any state, including mid-MEM_WAIT, HALTED and ERROR, SHALL take effect at the next edge.

Verification
REQ-035 Load-use case: ex_mem_to_reg=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cycles 0->1.
REQ-036 Branch case: ex_branch_taken=1 with a simultaneous load-use -> flush=1, bubble=1, pc_sel_target=1, pc_en=1, and no load-use stall.
REQ-037 Memory wait case: mem_busy=1 for 4 cycles with ex_branch_taken=1 -> enables 0 for 4 cycles, then 1 cycle with pc_sel_target=1, stall_cycles=4.
REQ-038 Timeout case: mem_busy held 256 cycles with MEM_TIMEOUT=255 -> err=1, enables 0, still err after mem_busy drops.
REQ-039 Halt case: wb_halt=1 -> halted=1 next cycle, enables 0; rst=0 for one edge -> RUN, halted=0, stall_cycles=0.
REQ-040 Saturation case: stall_cycles preloaded near 16'hFFFF via long stalls -> stall_cycles stays at 16'hFFFF.
